cnt_cmd_seq: RTL
================

CNT_CMD_SEQ -- requirements
Module: cnt_cmd_seq

Interface
REQ-001 Parameter COUNTER_WIDTH, default 4: width of the downstream up/down counter and of exp_count.
REQ-002 Parameter LEN_WIDTH, default 8: width of cmd_len.
REQ-003 clk  input  1  single clock; all logic samples on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-007 cmd_dir  input  1  command direction: 1 = count up, 0 = count down.
REQ-008 cmd_len  input  LEN_WIDTH  number of counter steps to request.
REQ-009 ovflw  input  1  overflow flag from the downstream counter (registered, sticky).
REQ-010 act  output  1  counter enable to the downstream counter.
REQ-011 up_dwn_n  output  1  direction to the downstream counter.
REQ-012 busy  output  1  high while a command is executing (RUN state).
REQ-013 done  output  1  one-cycle pulse when a command completes.
REQ-014 rej  output  1  one-cycle pulse when a command is rejected; driven only with the guard compiled in.
REQ-015 err  output  1  sticky error flag, high in ERR state.
REQ-016 exp_count  output  COUNTER_WIDTH  shadow of the expected downstream count value.

Function
REQ-017 State machine: IDLE, RUN, ERR; all outputs are registered or decoded from state, so the block is Moore with no input-to-output combinational path.
REQ-018 cmd_ready = 1 only in IDLE.
REQ-019 Accept in IDLE with cmd_len > 0 and not rejected:
  - load remaining-length register with cmd_len;
  - latch up_dwn_n = cmd_dir;
  - move to RUN on the next cycle.
REQ-020 In RUN:
  - act = 1 and busy = 1 every cycle;
  - remaining length decrements by 1 per cycle;
  - exp_count increments or decrements by 1 per cycle, per up_dwn_n, modulo 2^COUNTER_WIDTH.
REQ-021 Run length: act is high for exactly cmd_len consecutive cycles; after the cycle with remaining length 1, the state returns to IDLE.
REQ-022 done pulses high in the first IDLE cycle after RUN.
REQ-023 Accept with cmd_len = 0: no act, stay IDLE, done pulses on the next cycle.
REQ-024 Back-to-back commands: at least one act-low cycle always separates commands; a new command can be accepted in the same cycle that done is high.
REQ-025 up_dwn_n holds its last value outside RUN.
REQ-026 ovflw sampled high in IDLE or RUN:
  - next state ERR;
  - any remaining length is discarded;
  - done is not pulsed.
REQ-027 ERR behaviour: act = 0, cmd_ready = 0, busy = 0, err = 1, exp_count frozen; ERR is left only by rst.
REQ-028 Simultaneous ovflw and last RUN cycle: ERR takes priority and done is not pulsed.
REQ-029 Simultaneous ovflw and cmd_valid in IDLE: the command is not accepted (cmd_ready is already high that cycle, but the transition to ERR wins; the command is treated as not consumed).

Reset
REQ-030 rst high on a rising edge forces the following:
  - state = IDLE, act = 0, up_dwn_n = 1, busy = 0;
  - done = 0, rej = 0, err = 0, exp_count = 0;
  - remaining length = 0.
REQ-031 rst asserted mid-RUN aborts the command; act is low from the next cycle and no done pulse is generated.
REQ-032 rst dominates all other inputs.

Configuration
REQ-033 Macro CNT_CMD_SEQ_GUARD_EN, when defined, rejects a command in IDLE when either:
  - cmd_dir = 1 and exp_count + cmd_len > 2^COUNTER_WIDTH - 1; or
  - cmd_dir = 0 and cmd_len > exp_count.
REQ-034 Comparison width for the guard: computed in max(COUNTER_WIDTH, LEN_WIDTH) + 1 bits, with no truncation.
REQ-035 Rejected command handling: it is consumed (handshake completes), rej pulses on the next cycle, there is no act, the state stays IDLE, and exp_count is unchanged.
REQ-036 Macro not defined:
  - no guard logic;
  - rej is tied to 0;
  - all commands execute, and overflow is handled only via ovflw and ERR.

Verification
REQ-037 With COUNTER_WIDTH = 4: after reset, issue cmd up, len 5 -> act high for exactly 5 cycles, up_dwn_n = 1, exp_count = 5, done pulses once, busy low afterwards.
REQ-038 Issue up len 3, then down len 2 offered continuously -> act gap of exactly 1 cycle, up_dwn_n switches to 0, exp_count = 1, two done pulses.
REQ-039 Issue len 0 -> no act, done pulses 1 cycle after acceptance, exp_count unchanged.
REQ-040 Guard built, exp_count = 0: up len 16 -> rej pulse, no act; up len 15 -> 15 act cycles, exp_count = 15, no ovflw.
REQ-041 Guard not built: force ovflw = 1 during RUN of up len 10 -> ERR next cycle, act = 0, err = 1, no done, cmd_ready stays low until rst.
REQ-042 Assert rst for 1 cycle mid-RUN of len 8 -> act low next cycle, all outputs at reset values, a new command is accepted afterwards.

Source files
------------

// File: rtl/cnt_cmd_seq.sv
// Command sequencer driving a downstream up/down counter; CNT_CMD_SEQ_GUARD_EN adds a range guard.
// Latency: accepted command runs the cycle after acceptance; done/rej pulse one cycle after the last step.
// Backpressure: cmd_ready high only in IDLE; ERR holds cmd_ready low until rst.
module cnt_cmd_seq #(
   parameter int COUNTER_WIDTH = 4,
   parameter int LEN_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_dir,
   input  logic [LEN_WIDTH-1:0]     cmd_len,
   input  logic                     ovflw,
   output logic                     act,
   output logic                     up_dwn_n,
   output logic                     busy,
   output logic                     done,
   output logic                     rej,
   output logic                     err,
   output logic [COUNTER_WIDTH-1:0] exp_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [LEN_WIDTH-1:0]   rem_len;
   logic                   cmd_take;
   logic                   cmd_bad;
   logic                   len_zero;
   logic                   run_last;

   // ovflw in IDLE wins over a pending handshake: the command stays unconsumed.
   assign cmd_take = (state == ST_IDLE) && cmd_valid && !ovflw;
   assign len_zero = (cmd_len == '0);
   assign run_last = (rem_len == LEN_WIDTH'(1));

`ifdef CNT_CMD_SEQ_GUARD_EN
   localparam int GW = ((COUNTER_WIDTH > LEN_WIDTH) ? COUNTER_WIDTH : LEN_WIDTH) + 1;
   localparam logic [GW-1:0] CNT_MAX = {{(GW-COUNTER_WIDTH){1'b0}}, {COUNTER_WIDTH{1'b1}}};

   logic [GW-1:0] cnt_ext;
   logic [GW-1:0] len_ext;
   logic [GW-1:0] up_sum;
   logic          rej_q;

   // One extra bit keeps the sum exact for any width combination.
   assign cnt_ext = GW'(exp_count);
   assign len_ext = GW'(cmd_len);
   assign up_sum  = cnt_ext + len_ext;
   assign cmd_bad = cmd_dir ? (up_sum > CNT_MAX) : (len_ext > cnt_ext);

   always_ff @(posedge clk) begin
      if (rst) begin
         rej_q <= 1'b0;
      end else begin
         rej_q <= cmd_take && cmd_bad;
      end
   end

   assign rej = rej_q;
`else
   assign cmd_bad = 1'b0;
   assign rej     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (ovflw) begin
               state_nxt = ST_ERR;
            end else if (cmd_valid && !len_zero && !cmd_bad) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ovflw) begin
               state_nxt = ST_ERR;
            end else if (run_last) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ERR:  state_nxt = ST_ERR;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      act       = 1'b0;
      busy      = 1'b0;
      err       = 1'b0;
      case (state)
         ST_IDLE: cmd_ready = 1'b1;
         ST_RUN: begin
            act  = 1'b1;
            busy = 1'b1;
         end
         ST_ERR:  err = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

   // exp_count follows every cycle act is high, including one cut short by ovflw.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_len   <= '0;
         up_dwn_n  <= 1'b1;
         done      <= 1'b0;
         exp_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_take && !cmd_bad) begin
                  if (len_zero) begin
                     done <= 1'b1;
                  end else begin
                     rem_len  <= cmd_len;
                     up_dwn_n <= cmd_dir;
                  end
               end
            end
            ST_RUN: begin
               exp_count <= up_dwn_n ? (exp_count + COUNTER_WIDTH'(1))
                                     : (exp_count - COUNTER_WIDTH'(1));
               if (ovflw) begin
                  rem_len <= '0;
               end else begin
                  rem_len <= rem_len - LEN_WIDTH'(1);
                  done    <= run_last;
               end
            end
            default: rem_len <= '0;
         endcase
      end
   end

endmodule
